// File: rtl/efpga_macc_seq_if.sv
// Handshake bundle between fabric streaming logic and the MACC sequencer:
// command channel, operand stream, result channel and a busy status.
interface efpga_macc_seq_if #(
    parameter int INPUT_WIDTH  = 18,
    parameter int OUTPUT_WIDTH = 40,
    parameter int LEN_WIDTH    = 8
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [LEN_WIDTH-1:0]    cmd_len;
    logic                    in_valid;
    logic                    in_ready;
    logic [INPUT_WIDTH-1:0]  in_a;
    logic [INPUT_WIDTH-1:0]  in_b;
    logic                    res_valid;
    logic                    res_ready;
    logic [OUTPUT_WIDTH-1:0] res_data;
    logic                    res_overflow;
    logic                    busy;

    // Fabric side issues commands and operands and consumes results.
    modport master (
        output cmd_valid, cmd_len, in_valid, in_a, in_b, res_ready,
        input  cmd_ready, in_ready, res_valid, res_data, res_overflow, busy
    );

    modport slave (
        input  cmd_valid, cmd_len, in_valid, in_a, in_b, res_ready,
        output cmd_ready, in_ready, res_valid, res_data, res_overflow, busy
    );
endinterface

// File: rtl/efpga_macc_seq.sv
// Dot-product sequencer: takes an N-pair command, streams pairs through a
// registered product stage into a wrapping accumulator, returns one result.
module efpga_macc_seq #(
    parameter int INPUT_WIDTH  = 18,
    parameter int OUTPUT_WIDTH = 40,
    parameter int LEN_WIDTH    = 8
) (
    input  logic            clk,
    input  logic            reset,
    efpga_macc_seq_if.slave bus
);
    localparam int PROD_WIDTH = 2 * INPUT_WIDTH;

    if (OUTPUT_WIDTH < PROD_WIDTH) begin : g_width_check
        $error("efpga_macc_seq: OUTPUT_WIDTH must be at least 2*INPUT_WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                  state_q,    state_d;
    logic [LEN_WIDTH-1:0]    rem_q,      rem_d;
    logic [PROD_WIDTH-1:0]   prod_q,     prod_d;
    logic                    prod_vld_q, prod_vld_d;
    logic [OUTPUT_WIDTH-1:0] acc_q,      acc_d;
    logic                    ovf_q,      ovf_d;
    logic [OUTPUT_WIDTH-1:0] res_data_q, res_data_d;
    logic                    res_ovf_q,  res_ovf_d;

    logic                    cmd_fire;
    logic                    in_fire;
    logic                    drain_done;
    logic [OUTPUT_WIDTH:0]   acc_sum;

    assign cmd_fire   = bus.cmd_valid && (state_q == S_IDLE);
    assign in_fire    = bus.in_valid && (state_q == S_RUN);
    assign drain_done = (state_q == S_DRAIN) && !prod_vld_q;

    // Extra top bit captures the carry out of the accumulator for the sticky flag.
    assign acc_sum = {1'b0, acc_q} + {{(OUTPUT_WIDTH + 1 - PROD_WIDTH){1'b0}}, prod_q};

    // NOTE: every signal written in a combinational block gets a default at the
    // top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    rem_d   = bus.cmd_len;
                    state_d = (bus.cmd_len != '0) ? S_RUN : S_DRAIN;
                end
            end
            S_RUN: begin
                if (bus.in_valid) begin
                    rem_d = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!prod_vld_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        prod_d     = prod_q;
        prod_vld_d = 1'b0;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        res_data_d = res_data_q;
        res_ovf_d  = res_ovf_q;

        // A zero product issued with the command gives every command, including
        // an empty one, the same one-cycle pipeline fill before the result load.
        if (cmd_fire) begin
            prod_d     = '0;
            prod_vld_d = 1'b1;
        end else if (in_fire) begin
            prod_d     = {{INPUT_WIDTH{1'b0}}, bus.in_a} * {{INPUT_WIDTH{1'b0}}, bus.in_b};
            prod_vld_d = 1'b1;
        end

        if (cmd_fire) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (prod_vld_q) begin
            acc_d = acc_sum[OUTPUT_WIDTH-1:0];
            ovf_d = ovf_q | acc_sum[OUTPUT_WIDTH];
        end

        if (drain_done) begin
            res_data_d = acc_q;
            res_ovf_d  = ovf_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rem_q      <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            res_data_q <= '0;
            res_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            res_data_q <= res_data_d;
            res_ovf_q  <= res_ovf_d;
        end
    end

    assign bus.cmd_ready    = (state_q == S_IDLE);
    assign bus.in_ready     = (state_q == S_RUN);
    assign bus.res_valid    = (state_q == S_DONE);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.res_data     = res_data_q;
    assign bus.res_overflow = res_ovf_q;

    // Result must not move while it is offered and not yet taken.
    a_res_stable: assert property (@(posedge clk) disable iff (reset)
        (state_q == S_DONE && !bus.res_ready) |=> ($stable(res_data_q) && $stable(res_ovf_q)));

    a_ready_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(bus.cmd_ready && bus.in_ready));

    a_run_has_work: assert property (@(posedge clk) disable iff (reset)
        (state_q == S_RUN) |-> (rem_q != '0));
endmodule
